// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [INSTR_W-1:0] PC_STEP    = 32'h0000_0004;

  // Fetch control: FETCH issues requests, DROP waits out a squashed
  // request, HOLD parks one returned instruction while ID is stalled.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc4;
    logic               valid;
  } if_id_t;

  // Force a fetch target onto a word boundary.
  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush (bubble) > stall (hold) > load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);

  // Bubble on reset or flush, otherwise capture unless ID is stalled.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake, skid buffer and IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_f,
  input  logic               flush_d,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_d,
  output logic [OP_W-1:0]    op_d,
  output logic [INSTR_W-1:0] pc_plus4_d,
  output logic               valid_d
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] pc_f;
  logic [INSTR_W-1:0] pc_plus4_f;
  logic [INSTR_W-1:0] pend_pc;
  logic [INSTR_W-1:0] buf_instr;
  logic [INSTR_W-1:0] buf_pc4;
  logic [INSTR_W-1:0] redirect_tgt;
  if_id_t             if_id_load;
  if_id_t             if_id_q;

  assign pc_plus4_f   = pc_f + PC_STEP;
  assign redirect_tgt = align_word(redirect_pc);

  // A request is outstanding in FETCH and DROP; the address is the PC,
  // which only moves when the outstanding request completes or in HOLD.
  assign imem_req  = (state != HOLD) && !reset;
  assign imem_addr = pc_f;

  // Candidate IF/ID contents; a bubble unless a real instruction is ready.
  always_comb begin
    if_id_load = '0;
    case (state)
      FETCH: begin
        if (imem_ready && !redirect) begin
          if_id_load = '{instr: imem_rdata, pc4: pc_plus4_f, valid: 1'b1};
        end
      end
      HOLD: begin
        if (!redirect) begin
          if_id_load = '{instr: buf_instr, pc4: buf_pc4, valid: 1'b1};
        end
      end
      default: ;
    endcase
  end

  // PC, fetch state machine, skid buffer and pending redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc_f      <= RESET_PC;
      pend_pc   <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc4   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              pc_f <= redirect_tgt;
            end else begin
              pc_f <= pc_plus4_f;
              if (stall_f) begin
                buf_instr <= imem_rdata;
                buf_pc4   <= pc_plus4_f;
                state     <= HOLD;
              end
            end
          end else if (redirect) begin
            pend_pc <= redirect_tgt;
            state   <= DROP;
          end
        end
        DROP: begin
          // Latest redirect wins, including one arriving with the ready.
          if (imem_ready) begin
            pc_f  <= redirect ? redirect_tgt : pend_pc;
            state <= FETCH;
          end else if (redirect) begin
            pend_pc <= redirect_tgt;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_f  <= redirect_tgt;
            state <= FETCH;
          end else if (!stall_f) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .flush (flush_d),
    .stall (stall_f),
    .d     (if_id_load),
    .q     (if_id_q)
  );

  assign instr_d    = if_id_q.instr;
  assign op_d       = if_id_q.instr[OP_MSB:OP_LSB];
  assign pc_plus4_d = if_id_q.pc4;
  assign valid_d    = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the fetch PC, drives the instruction-memory request handshake, and holds the IF/ID pipeline register whose `op_d` field feeds the main decoder in ID. It honours stall, flush and redirect from the hazard/branch logic in ID. It buffers one returned instruction when ID is stalled and discards stale instructions after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_f` in 1: ID cannot accept; hold IF/ID contents.
- `flush_d` in 1: clear IF/ID to a bubble next edge.
- `redirect` in 1: taken beq/bne, j or jal resolved in ID.
- `redirect_pc` in 32: new fetch address; bits [1:0] forced to 0.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word-aligned fetch address.
- `imem_ready` in 1: `imem_rdata` valid this cycle; completes the request.
- `imem_rdata` in 32: instruction word.
- `instr_d` out 32: IF/ID instruction.
- `op_d` out 6: `instr_d[31:26]`, to the main decoder.
- `pc_plus4_d` out 32: fetch PC + 4 of `instr_d`, for branch/jal targets.
- `valid_d` out 1: `instr_d` is a real instruction, not a bubble.

## Operation
- State `pc_f` (32), state machine {FETCH, DROP, HOLD}, one-entry buffer {`buf_instr`, `buf_pc4`}, pending-redirect register `pend_pc`.
- Reset: `pc_f`=RESET_PC, state=FETCH, `instr_d`=0 (NOP), `pc_plus4_d`=0, `valid_d`=0. While `reset` is high, `imem_req`=0.
- `imem_req`=1 in FETCH and DROP. `imem_addr`=`pc_f`. A request is committed once issued: `imem_addr` stays stable until `imem_ready`.
- FETCH:
  - ready & !redirect & !stall_f: IF/ID <= {rdata, pc_f+4, 1}; `pc_f`+=4.
  - ready & !redirect & stall_f: buffer <= {rdata, pc_f+4}; `pc_f`+=4; go HOLD.
  - ready & redirect: discard rdata; `pc_f`<=redirect_pc.
  - !ready & redirect: `pend_pc`<=redirect_pc; go DROP.
  - !ready & !stall_f: IF/ID loads a bubble (`valid_d`=0, `instr_d`=0).
- DROP: wait for ready; discard rdata; `pc_f`<=`pend_pc`; go FETCH. A new redirect in DROP overwrites `pend_pc` (latest wins).
- HOLD: `imem_req`=0.
  - redirect: discard buffer; `pc_f`<=redirect_pc; go FETCH.
  - else !stall_f: IF/ID <= {buf_instr, buf_pc4, 1}; go FETCH.
- Any redirect squashes the instruction currently being fetched. There is no delay slot.
- IF/ID priority: reset > flush_d (bubble) > stall_f (hold) > load.
- PC/state priority: reset > redirect > normal.
- `flush_d` with stall_f: bubble wins. `flush_d` without redirect does not change `pc_f`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Zero-wait memory (ready tied high): one instruction per cycle. An instruction accepted at edge N is on `instr_d` in cycle N+1.
- First fetch: `imem_addr`=RESET_PC in the first cycle after reset deasserts; `valid_d`=1 one cycle later.
- Redirect at edge N: `imem_addr`=redirect_pc in cycle N+1 (FETCH/HOLD). From DROP, it appears the cycle after the outstanding ready.
- Redirect penalty: one bubble on `valid_d` with zero-wait memory.
- HOLD release: buffered instruction on `instr_d` the cycle after `stall_f` drops. The new request issues that same cycle.

## Structure
- `mips_pkg`: `fetch_state_t` enum {FETCH, DROP, HOLD}, `NOP_INSTR`=32'h0, `INSTR_W`=32, `OP_MSB`/`OP_LSB`=31/26.
- Sub-module `if_id_reg`: IF/ID register with reset/flush/stall-enable priority. `fetch_stage` contains the PC, the FSM and the buffer.

## Test plan
- Reset, RESET_PC=0x100, ready=1 → `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `valid_d` rises the cycle after the first fetch; `pc_plus4_d`=0x104.
- Redirect to 0x2000 while fetching 0x10C with ready=1 → 0x10C data never reaches `instr_d`; next `imem_addr`=0x2000; `pc_plus4_d`=0x2004 two cycles later.
- ready low 3 cycles with redirect to 0x400 in the second cycle → `imem_addr` held at the old PC until ready; stale data dropped; then `imem_addr`=0x400.
- stall_f high 2 cycles as 0xDEADBEEF returns → `instr_d` holds the prior instruction, `imem_req`=0 in HOLD; 0xDEADBEEF appears the cycle after the stall clears; no instruction lost or duplicated.
- flush_d and stall_f together → `valid_d`=0, `instr_d`=0 next cycle; `pc_f` unchanged.
- Redirect to 0xFFFF_FFFC → next fetch addresses 0xFFFF_FFFC then 0x0000_0000.
